// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle control unit: FSM states, opcode/funct
// values, ALU operation codes and PC source selects.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXEC_R,
    ALU_WB_R,
    EXEC_I,
    ALU_WB_I,
    BRANCH,
    JUMP,
    ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decoder; valid is low for functs the datapath
// does not implement.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FUNCT_ADD: alu_control = ALU_ADD;
      FUNCT_SUB: alu_control = ALU_SUB;
      FUNCT_AND: alu_control = ALU_AND;
      FUNCT_OR:  alu_control = ALU_OR;
      FUNCT_NOR: alu_control = ALU_NOR;
      FUNCT_SLT: alu_control = ALU_SLT;
      default:   valid       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, counts retired instructions and flags unsupported opcodes.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             ALUScr,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [3:0]       ALUControl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  state_t             state;
  state_t             state_nxt;
  logic               retire;
  logic [CNT_W-1:0]   instret_q;
  logic               illegal_q;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [3:0]         funct_alu;
  logic               funct_valid;
  logic               unused_instr_bits;

  assign opcode            = instruction[31:26];
  assign funct             = instruction[5:0];
  assign unused_instr_bits = ^instruction[25:6];

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (funct_alu),
    .valid       (funct_valid)
  );

  // Next-state and retire decode
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      FETCH:    if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = funct_valid ? EXEC_R : ILLEGAL;
          OP_ADDI:      state_nxt = EXEC_I;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          default:      state_nxt = ILLEGAL;
        endcase
      end
      MEMADR:   state_nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_nxt = MEMWB;
      MEMWB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      MEMWRITE: begin
        if (mem_ready) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      EXEC_R:   state_nxt = ALU_WB_R;
      EXEC_I:   state_nxt = ALU_WB_I;
      ALU_WB_R, ALU_WB_I, BRANCH, JUMP: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      ILLEGAL:  state_nxt = ILLEGAL;
      default:  state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_nxt == ILLEGAL) illegal_q <= 1'b1;
    end
  end

  logic       alusrc_c;
  logic       regwrite_c;
  logic       regdst_c;
  logic [3:0] aluctl_c;
  logic       memread_c;
  logic       memwrite_c;
  logic       memtoreg_c;
  logic       iord_c;
  logic       irwrite_c;
  logic       pcwrite_c;
  logic [1:0] pcsrc_c;

  // Moore output decode; the FETCH IR/PC load is qualified by the memory handshake
  always_comb begin
    alusrc_c   = 1'b0;
    regwrite_c = 1'b0;
    regdst_c   = 1'b0;
    aluctl_c   = ALU_AND;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    memtoreg_c = 1'b0;
    iord_c     = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    pcsrc_c    = PCSRC_PLUS4;
    case (state)
      FETCH: begin
        memread_c = 1'b1;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
      end
      MEMADR: begin
        alusrc_c = 1'b1;
        aluctl_c = ALU_ADD;
      end
      MEMREAD: begin
        alusrc_c  = 1'b1;
        aluctl_c  = ALU_ADD;
        memread_c = 1'b1;
        iord_c    = 1'b1;
      end
      MEMWB: begin
        alusrc_c   = 1'b1;
        aluctl_c   = ALU_ADD;
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
      end
      MEMWRITE: begin
        alusrc_c   = 1'b1;
        aluctl_c   = ALU_ADD;
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
      end
      EXEC_R:   aluctl_c = funct_alu;
      ALU_WB_R: begin
        aluctl_c   = funct_alu;
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
      end
      EXEC_I: begin
        alusrc_c = 1'b1;
        aluctl_c = ALU_ADD;
      end
      ALU_WB_I: begin
        alusrc_c   = 1'b1;
        aluctl_c   = ALU_ADD;
        regwrite_c = 1'b1;
      end
      BRANCH: begin
        aluctl_c  = ALU_SUB;
        pcsrc_c   = PCSRC_BRANCH;
        pcwrite_c = Zero;
      end
      JUMP: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  // Reset holds every control low regardless of state
  assign ALUScr     = rst_n & alusrc_c;
  assign RegWrite   = rst_n & regwrite_c;
  assign RegDst     = rst_n & regdst_c;
  assign ALUControl = rst_n ? aluctl_c : 4'b0000;
  assign MemRead    = rst_n & memread_c;
  assign MemWrite   = rst_n & memwrite_c;
  assign MemtoReg   = rst_n & memtoreg_c;
  assign IorD       = rst_n & iord_c;
  assign IRWrite    = rst_n & irwrite_c;
  assign PCWrite    = rst_n & pcwrite_c;
  assign PCSrc      = rst_n ? pcsrc_c : 2'b00;
  assign illegal    = rst_n & illegal_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control: each instruction is expanded into
// a table of per-phase control words and checked cycle by cycle.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg;
  logic        IorD, IRWrite, PCWrite, illegal;
  logic [3:0]  ALUControl;
  logic [1:0]  PCSrc;
  logic [31:0] instret;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .Zero(Zero),
    .mem_ready(mem_ready), .ALUScr(ALUScr), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUControl(ALUControl), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       alusrc, regwrite, regdst;
    logic [3:0] aluctl;
    logic       memread, memwrite, memtoreg, iord, irwrite, pcwrite;
    logic [1:0] pcsrc;
    logic       ill;
  } ctrl_t;

  typedef struct {
    ctrl_t c;
    bit    waits, retires, is_fetch, is_branch;
  } step_t;

  step_t       plan[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_instret = '0;
  int          stall_mode = -1;
  int          zero_mode = -1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic ctrl_t observed();
    return {ALUScr, RegWrite, RegDst, ALUControl, MemRead, MemWrite, MemtoReg,
            IorD, IRWrite, PCWrite, PCSrc, illegal};
  endfunction

  function automatic logic [4:0] ref_alu(input logic [5:0] f);
    case (f)
      6'h20: return {1'b1, 4'b0010};
      6'h22: return {1'b1, 4'b0110};
      6'h24: return {1'b1, 4'b0000};
      6'h25: return {1'b1, 4'b0001};
      6'h27: return {1'b1, 4'b1100};
      6'h2A: return {1'b1, 4'b0111};
      default: return 5'b0;
    endcase
  endfunction

  function automatic step_t mk(input ctrl_t c, input bit w, input bit r, input bit f, input bit b);
    step_t s;
    s.c = c; s.waits = w; s.retires = r; s.is_fetch = f; s.is_branch = b;
    return s;
  endfunction

  task automatic push_illegal();
    ctrl_t c;
    c = '0; c.ill = 1'b1;
    repeat (10) plan.push_back(mk(c, 0, 0, 0, 0));
  endtask

  // Phase table of each instruction class
  task automatic build_plan(input logic [31:0] ins);
    ctrl_t      c;
    logic [4:0] fa;
    plan.delete();
    c = '0; c.memread = 1'b1;
    plan.push_back(mk(c, 1, 0, 1, 0));
    c = '0;
    plan.push_back(mk(c, 0, 0, 0, 0));
    case (ins[31:26])
      6'h00: begin
        fa = ref_alu(ins[5:0]);
        if (fa[4]) begin
          c = '0; c.aluctl = fa[3:0];
          plan.push_back(mk(c, 0, 0, 0, 0));
          c.regwrite = 1'b1; c.regdst = 1'b1;
          plan.push_back(mk(c, 0, 1, 0, 0));
        end else push_illegal();
      end
      6'h08: begin
        c = '0; c.alusrc = 1'b1; c.aluctl = 4'b0010;
        plan.push_back(mk(c, 0, 0, 0, 0));
        c.regwrite = 1'b1;
        plan.push_back(mk(c, 0, 1, 0, 0));
      end
      6'h23: begin
        c = '0; c.alusrc = 1'b1; c.aluctl = 4'b0010;
        plan.push_back(mk(c, 0, 0, 0, 0));
        c.memread = 1'b1; c.iord = 1'b1;
        plan.push_back(mk(c, 1, 0, 0, 0));
        c = '0; c.alusrc = 1'b1; c.aluctl = 4'b0010; c.regwrite = 1'b1; c.memtoreg = 1'b1;
        plan.push_back(mk(c, 0, 1, 0, 0));
      end
      6'h2B: begin
        c = '0; c.alusrc = 1'b1; c.aluctl = 4'b0010;
        plan.push_back(mk(c, 0, 0, 0, 0));
        c.memwrite = 1'b1; c.iord = 1'b1;
        plan.push_back(mk(c, 1, 1, 0, 0));
      end
      6'h04: begin
        c = '0; c.aluctl = 4'b0110; c.pcsrc = 2'b01;
        plan.push_back(mk(c, 0, 1, 0, 1));
      end
      6'h02: begin
        c = '0; c.pcwrite = 1'b1; c.pcsrc = 2'b10;
        plan.push_back(mk(c, 0, 1, 0, 0));
      end
      default: push_illegal();
    endcase
  endtask

  task automatic run_step(input step_t s);
    int    n;
    int    stalls;
    bit    done;
    ctrl_t e;
    n = 0; done = 0;
    stalls = s.is_fetch ? ((stall_mode >= 0) ? 0 : -1) : stall_mode;
    while (!done) begin
      Zero = (zero_mode >= 0) ? zero_mode[0] : 1'($urandom);
      if (s.waits)
        mem_ready = (stalls >= 0) ? (n >= stalls) : (($urandom_range(0, 2) != 0) || n >= 6);
      else
        mem_ready = 1'($urandom);
      @(negedge clk);
      e = s.c;
      if (s.is_fetch && mem_ready) begin
        e.irwrite = 1'b1;
        e.pcwrite = 1'b1;
      end
      if (s.is_branch) e.pcwrite = Zero;
      check_val("ctrl", 64'(observed()), 64'(e));
      check_val("instret", 64'(instret), 64'(exp_instret));
      @(posedge clk); #1;
      if (!s.waits || mem_ready) done = 1;
      if (done && s.retires) exp_instret = exp_instret + 32'd1;
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      check_val("rst_ctrl", 64'(observed()), 64'd0);
      check_val("rst_instret", 64'(instret), 64'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  task automatic run_instr(input logic [31:0] ins);
    build_plan(ins);
    instruction = ins;
    foreach (plan[i]) run_step(plan[i]);
    if (plan[plan.size()-1].c.ill) do_reset();
  endtask

  // sw stalled in MEMWRITE, then reset before the write completes
  task automatic abort_sw();
    ctrl_t e;
    build_plan(32'hAC220008);
    instruction = 32'hAC220008;
    for (int i = 0; i < 3; i++) run_step(plan[i]);
    mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("sw_stall", 64'(observed()), 64'(plan[3].c));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_gate", 64'(observed()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = '0;
    @(negedge clk);
    e = '0; e.memread = 1'b1;
    check_val("abort_fetch", 64'(observed()), 64'(e));
    check_val("abort_instret", 64'(instret), 64'(exp_instret));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    int k;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    k = $urandom_range(0, 99);
    op = ops[$urandom_range(0, 5)];
    fn = (op == 6'h00) ? fns[$urandom_range(0, 5)] : 6'($urandom);
    if (k < 3) begin
      op = 6'h00;
      fn = 6'h3F;
    end else if (k < 6) begin
      op = 6'h3F;
    end
    return {op, 20'($urandom), fn};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    stall_mode = 0;
    run_instr(32'h00221820);
    stall_mode = 3;
    run_instr(32'h8C220004);
    stall_mode = 0;
    zero_mode = 1;
    run_instr(32'h10220003);
    zero_mode = 0;
    run_instr(32'h10220003);
    zero_mode = -1;
    run_instr(32'hFC000000);
    run_instr(32'h0022183F);
    abort_sw();
    stall_mode = -1;
    for (int i = 0; i < 300; i++) run_instr(rand_instr());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
